prio_arbiter_rr: RTL and testbench

//  Parametrised, registered successor to the 8-to-3 priority encoder.
//  - Accepts an N-bit request vector and returns the index and one-hot grant of the winning request.
//  - Two selection modes: fixed priority (MSB wins) or rotating round-robin.
//  - Output side uses a valid/ready handshake, so the block sits between request sources and a

---
 rtl/prio_arbiter_rr.sv | 56 +++++
 tb/tb_prio_arbiter_rr.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/prio_arbiter_rr.sv
// prio_arbiter_rr: registered fixed/round-robin priority arbiter with valid/ready output
module prio_arbiter_rr #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         mode,
  input  logic [N-1:0] req,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] idx,
  output logic [N-1:0] grant,
  output logic         none
);
  logic [W-1:0] rr_ptr, ptr, win;
  logic         load, slot;
  int           best, d;
  assign slot = ~out_valid | out_ready;
  assign load = en & |req & slot;
  // Rank each request by its distance below ptr (mod N); the smallest distance wins.
  always_comb begin
    ptr  = mode ? rr_ptr : W'(N-1);
    win  = '0;
    best = N;
    d    = 0;
    for (int j = 0; j < N; j++) begin
      d = int'(ptr) - j;
      if (d < 0) d += N;
      if (req[j] && d < best) begin
        best = d;
        win  = W'(j);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      idx       <= '0;
      grant     <= '0;
      none      <= 1'b0;
      rr_ptr    <= W'(N-1);
    end else begin
      none <= en & ~|req & slot;
      if (load) begin
        out_valid <= 1'b1;
        idx       <= win;
        grant     <= N'(1) << win;
        if (mode) rr_ptr <= (win == '0) ? W'(N-1) : win - 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_prio_arbiter_rr.sv
// tb_prio_arbiter_rr: directed checks of prio_arbiter_rr at N=8 and N=5
module tb_prio_arbiter_rr;
  logic       clk = 1'b0;
  logic       rst, en, mode, out_ready, out_valid, none;
  logic [7:0] req, grant;
  logic [2:0] idx;
  logic       en5, mode5, ready5, valid5, none5;
  logic [4:0] req5, grant5;
  logic [2:0] idx5;
  int         vectors = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

  prio_arbiter_rr #(.N(8)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .req(req), .out_ready(out_ready),
    .out_valid(out_valid), .idx(idx), .grant(grant), .none(none)
  );

  prio_arbiter_rr #(.N(5)) dut5 (
    .clk(clk), .rst(rst), .en(en5), .mode(mode5), .req(req5), .out_ready(ready5),
    .out_valid(valid5), .idx(idx5), .grant(grant5), .none(none5)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_res(input string tag, input logic v, input logic [2:0] i, input logic n);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".idx"}, 32'(idx), 32'(i));
    chk({tag, ".grant"}, 32'(grant), 32'(8'(1) << i));
    chk({tag, ".none"}, 32'(none), 32'(n));
  endtask

  initial begin
    int rr_seq[9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
    int alt_seq[4] = '{0, 7, 0, 7};
    int n5_seq[6] = '{4, 3, 2, 1, 0, 4};
    rst = 1'b1; en = 1'b0; mode = 1'b0; req = '0; out_ready = 1'b0;
    en5 = 1'b0; mode5 = 1'b0; req5 = '0; ready5 = 1'b0;
    step();
    step();
    chk("rst.valid", 32'(out_valid), 0);
    chk("rst.idx", 32'(idx), 0);
    chk("rst.grant", 32'(grant), 0);
    chk("rst.none", 32'(none), 0);
    chk("rst5.valid", 32'(valid5), 0);

    rst = 1'b0; en = 1'b1; mode = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      req = 8'(1) << k;
      step();
      chk_res($sformatf("walk%0d", k), 1'b1, 3'(k), 1'b0);
    end

    req = 8'b1010_0110;
    step();
    chk_res("fixA6", 1'b1, 3'd7, 1'b0);
    req = 8'b0000_0110;
    step();
    chk_res("fix06", 1'b1, 3'd2, 1'b0);
    req = 8'h00;
    step();
    chk("empty.none", 32'(none), 1);
    chk("empty.valid", 32'(out_valid), 0);
    en = 1'b0;
    step();
    chk("empty_en0.none", 32'(none), 0);

    en = 1'b1; mode = 1'b1; req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      step();
      chk_res($sformatf("rrFF_%0d", k), 1'b1, 3'(rr_seq[k]), 1'b0);
    end

    req = 8'b1000_0001;
    for (int k = 0; k < 4; k++) begin
      step();
      chk_res($sformatf("rr81_%0d", k), 1'b1, 3'(alt_seq[k]), 1'b0);
    end

    req = 8'h10;
    step();
    chk_res("stall_load", 1'b1, 3'd4, 1'b0);
    out_ready = 1'b0; req = 8'h80;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_res($sformatf("stall%0d", k), 1'b1, 3'd4, 1'b0);
    end
    out_ready = 1'b1;
    step();
    chk_res("stall_release", 1'b1, 3'd7, 1'b0);

    en = 1'b0; req = 8'hFF;
    step();
    chk("en0.valid", 32'(out_valid), 0);
    chk("en0.none", 32'(none), 0);
    step();
    chk("en0b.valid", 32'(out_valid), 0);
    chk("en0b.none", 32'(none), 0);

    en = 1'b1; out_ready = 1'b0;
    step();
    chk_res("pre_rst_load", 1'b1, 3'd6, 1'b0);
    step();
    chk_res("pre_rst_hold", 1'b1, 3'd6, 1'b0);
    rst = 1'b1;
    step();
    chk("midrst.valid", 32'(out_valid), 0);
    chk("midrst.idx", 32'(idx), 0);
    chk("midrst.grant", 32'(grant), 0);
    chk("midrst.none", 32'(none), 0);
    rst = 1'b0; out_ready = 1'b1;
    step();
    chk_res("ptr_after_rst", 1'b1, 3'd7, 1'b0);

    mode = 1'b0; req = 8'b1000_0001;
    step();
    chk_res("mode_switch_fixed", 1'b1, 3'd7, 1'b0);
    mode = 1'b1;
    step();
    chk_res("mode_switch_rr", 1'b1, 3'd0, 1'b0);

    en5 = 1'b1; mode5 = 1'b1; ready5 = 1'b1; req5 = 5'b11111;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("n5_%0d.idx", k), 32'(idx5), 32'(n5_seq[k]));
      chk($sformatf("n5_%0d.grant", k), 32'(grant5), 32'(5'(1) << n5_seq[k]));
      chk($sformatf("n5_%0d.valid", k), 32'(valid5), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
